// File: rtl/game_scene_ctrl_if.sv
// ---------------------------------------------------------------------------
// game_scene_ctrl_if
// Event and renderer-configuration bundle between game logic and the
// scene controller. The game-logic side (master) drives the one-cycle
// event pulses and the start level; the controller (slave) drives the
// registered scene/life/score/visibility outputs.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface game_scene_ctrl_if;
  logic       start;
  logic       frame_tick;
  logic       player_hit;
  logic       enemy_kill;
  logic       boss_kill;
  logic [1:0] scene;
  logic [1:0] life;
  logic [3:0] score0;
  logic [3:0] score1;
  logic [3:0] score2;
  logic [3:0] score3;
  logic       reimuE;
  logic       game_active;

  modport master (
    output start, frame_tick, player_hit, enemy_kill, boss_kill,
    input  scene, life, score0, score1, score2, score3, reimuE, game_active
  );

  modport slave (
    input  start, frame_tick, player_hit, enemy_kill, boss_kill,
    output scene, life, score0, score1, score2, score3, reimuE, game_active
  );
endinterface

`default_nettype wire

// File: rtl/game_scene_ctrl.sv
// ---------------------------------------------------------------------------
// game_scene_ctrl
// Game-flow controller feeding the VGA renderer: sequences
// TITLE -> PLAY -> OVER/CLEAR -> TITLE, tracks lives and a four-digit
// saturating BCD score, and drives the player sprite enable.
// Optional feature macro: SCENE_CTRL_INVULN_EN (post-hit invulnerability
// window with sprite blink). Without it every hit in PLAY is accepted.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module game_scene_ctrl #(
  parameter int         INVULN_FRAMES = 120,
  parameter int         BLINK_SHIFT   = 2,
  parameter int         HOLD_FRAMES   = 60,
  parameter logic [3:0] ENM_PTS       = 4'd1,
  parameter logic [3:0] BOSS_PTS      = 4'd5
) (
  input wire logic         clk_25m,
  input wire logic         rst,
  game_scene_ctrl_if.slave bus
);

  // Elaboration-time parameter range guards
  if (INVULN_FRAMES < 1 || INVULN_FRAMES > 255) begin : g_bad_invuln
    $error("INVULN_FRAMES must be 1..255");
  end
  if (BLINK_SHIFT < 0 || BLINK_SHIFT > 7) begin : g_bad_blink
    $error("BLINK_SHIFT must be 0..7");
  end
  if (HOLD_FRAMES < 1 || HOLD_FRAMES > 255) begin : g_bad_hold
    $error("HOLD_FRAMES must be 1..255");
  end
  if (ENM_PTS > 4'd9 || BOSS_PTS > 4'd9) begin : g_bad_pts
    $error("ENM_PTS and BOSS_PTS must be BCD 0..9");
  end

  typedef enum logic [1:0] {
    TITLE = 2'b00,
    PLAY  = 2'b01,
    OVER  = 2'b10,
    CLEAR = 2'b11
  } scene_t;

  localparam logic [7:0] c_hold = 8'(HOLD_FRAMES);

  scene_t     r_scene;
  logic [1:0] r_life;
  logic [3:0] r_d0, r_d1, r_d2, r_d3;
  logic       r_reimu;
  logic       r_active;
  logic [7:0] r_hold;
  logic       r_start_q;

  logic       w_start_edge;
  logic       w_hit_ok;
  logic       w_play_vis;

  assign w_start_edge = bus.start & ~r_start_q;

  // Decimal score adder: enemy points at units, boss points at hundreds,
  // ripple carry through all four digits, saturate to 9999 on overflow
  logic [4:0] w_sum0, w_sum1, w_sum2, w_sum3;
  logic       w_c0, w_c1, w_c2, w_c3;
  logic [3:0] w_n0, w_n1, w_n2, w_n3;

  always_comb begin
    w_sum0 = {1'b0, r_d0} + (bus.enemy_kill ? {1'b0, ENM_PTS} : 5'd0);
    w_c0   = (w_sum0 >= 5'd10);
    w_n0   = w_c0 ? 4'(w_sum0 - 5'd10) : w_sum0[3:0];

    w_sum1 = {1'b0, r_d1} + {4'd0, w_c0};
    w_c1   = (w_sum1 >= 5'd10);
    w_n1   = w_c1 ? 4'(w_sum1 - 5'd10) : w_sum1[3:0];

    w_sum2 = {1'b0, r_d2} + (bus.boss_kill ? {1'b0, BOSS_PTS} : 5'd0) + {4'd0, w_c1};
    w_c2   = (w_sum2 >= 5'd10);
    w_n2   = w_c2 ? 4'(w_sum2 - 5'd10) : w_sum2[3:0];

    w_sum3 = {1'b0, r_d3} + {4'd0, w_c2};
    w_c3   = (w_sum3 >= 5'd10);
    w_n3   = w_c3 ? 4'(w_sum3 - 5'd10) : w_sum3[3:0];

    if (w_c3) begin
      w_n0 = 4'd9;
      w_n1 = 4'd9;
      w_n2 = 4'd9;
      w_n3 = 4'd9;
    end
  end

`ifdef SCENE_CTRL_INVULN_EN
  localparam logic [7:0] c_invuln = 8'(INVULN_FRAMES);

  logic [7:0] r_inv_cnt;
  logic [7:0] w_inv_next;

  assign w_hit_ok = bus.player_hit & (r_inv_cnt == 8'd0);

  // Next invulnerability count: a non-fatal accepted hit reloads the window
  // and takes precedence over the frame decrement in the same cycle
  always_comb begin
    if (r_scene == PLAY && w_hit_ok && r_life != 2'd1) begin
      w_inv_next = c_invuln;
    end else if (bus.frame_tick && r_inv_cnt != 8'd0) begin
      w_inv_next = r_inv_cnt - 8'd1;
    end else begin
      w_inv_next = r_inv_cnt;
    end
  end

  // Sprite blinks on bit BLINK_SHIFT of the count, solid when it reaches zero
  assign w_play_vis = (w_inv_next == 8'd0) | ~w_inv_next[BLINK_SHIFT];

  // Invulnerability counter register, cleared at the start of each game
  always_ff @(posedge clk_25m) begin
    if (rst) begin
      r_inv_cnt <= 8'd0;
    end else if (r_scene == TITLE && w_start_edge) begin
      r_inv_cnt <= 8'd0;
    end else begin
      r_inv_cnt <= w_inv_next;
    end
  end
`else
  assign w_hit_ok   = bus.player_hit;
  assign w_play_vis = 1'b1;
`endif

  // Scene state machine with lives, score, hold timer and registered outputs.
  // start_q follows start even during reset so a button held through reset
  // does not register as a press until it is released and pressed again.
  always_ff @(posedge clk_25m) begin
    r_start_q <= bus.start;
    if (rst) begin
      r_scene  <= TITLE;
      r_life   <= 2'd3;
      r_d0     <= 4'd0;
      r_d1     <= 4'd0;
      r_d2     <= 4'd0;
      r_d3     <= 4'd0;
      r_reimu  <= 1'b0;
      r_active <= 1'b0;
      r_hold   <= 8'd0;
    end else begin
      case (r_scene)
        TITLE: begin
          if (w_start_edge) begin
            r_scene  <= PLAY;
            r_life   <= 2'd3;
            r_d0     <= 4'd0;
            r_d1     <= 4'd0;
            r_d2     <= 4'd0;
            r_d3     <= 4'd0;
            r_reimu  <= 1'b1;
            r_active <= 1'b1;
          end
        end
        PLAY: begin
          if (bus.enemy_kill || bus.boss_kill) begin
            r_d0 <= w_n0;
            r_d1 <= w_n1;
            r_d2 <= w_n2;
            r_d3 <= w_n3;
          end
          if (w_hit_ok && r_life == 2'd1) begin
            // Losing the last life wins over a simultaneous boss kill
            r_life   <= 2'd0;
            r_scene  <= OVER;
            r_hold   <= 8'd0;
            r_reimu  <= 1'b0;
            r_active <= 1'b0;
          end else begin
            if (w_hit_ok) begin
              r_life <= r_life - 2'd1;
            end
            if (bus.boss_kill) begin
              r_scene  <= CLEAR;
              r_hold   <= 8'd0;
              r_reimu  <= 1'b0;
              r_active <= 1'b0;
            end else begin
              r_reimu <= w_play_vis;
            end
          end
        end
        default: begin
          if (w_start_edge && r_hold == c_hold) begin
            r_scene <= TITLE;
          end else if (bus.frame_tick && r_hold != c_hold) begin
            r_hold <= r_hold + 8'd1;
          end
        end
      endcase
    end
  end

  assign bus.scene       = r_scene;
  assign bus.life        = r_life;
  assign bus.score0      = r_d0;
  assign bus.score1      = r_d1;
  assign bus.score2      = r_d2;
  assign bus.score3      = r_d3;
  assign bus.reimuE      = r_reimu;
  assign bus.game_active = r_active;

endmodule

`default_nettype wire
